// File: rtl/axis_dw_pkg.sv
// Shared definitions for the axis_dw_* width converters (axis_dw_pack, axis_dw_shift).
// Default geometry plus the member/user types both converters exchange.
`ifndef TUSER_WIDTH_LRELU_IN
`define TUSER_WIDTH_LRELU_IN 8
`endif

package axis_dw_pkg;

  localparam int DEF_WORD_WIDTH  = 8;
  localparam int DEF_UNITS       = 2;
  localparam int DEF_MEMBERS     = 24;
  localparam int DEF_TUSER_WIDTH = `TUSER_WIDTH_LRELU_IN;
  localparam int BITS_MEMBERS    = $clog2(DEF_MEMBERS);

  typedef logic [DEF_UNITS-1:0][DEF_WORD_WIDTH-1:0] member_t;
  typedef logic [DEF_TUSER_WIDTH-1:0]               user_t;

endpackage

// File: rtl/axis_dw_pack_if.sv
// Narrow input stream and wide packed output stream of axis_dw_pack.
// master = the environment around the converter, slave = the converter itself.
interface axis_dw_pack_if #(
  parameter int WORD_WIDTH  = axis_dw_pkg::DEF_WORD_WIDTH,
  parameter int UNITS       = axis_dw_pkg::DEF_UNITS,
  parameter int MEMBERS     = axis_dw_pkg::DEF_MEMBERS,
  parameter int TUSER_WIDTH = axis_dw_pkg::DEF_TUSER_WIDTH
);

  logic                                          s_valid;
  logic                                          s_ready;
  logic [UNITS-1:0][WORD_WIDTH-1:0]              s_data;
  logic [TUSER_WIDTH-1:0]                        s_user;
  logic                                          s_last;

  logic                                          m_valid;
  logic                                          m_ready;
  logic [MEMBERS-1:0][UNITS-1:0][WORD_WIDTH-1:0] m_data;
  logic [MEMBERS-1:0][TUSER_WIDTH-1:0]           m_user;
  logic [MEMBERS-1:0]                            m_keep;
  logic                                          m_last;

  modport master (
    output s_valid, s_data, s_user, s_last, m_ready,
    input  s_ready, m_valid, m_data, m_user, m_keep, m_last
  );

  modport slave (
    input  s_valid, s_data, s_user, s_last, m_ready,
    output s_ready, m_valid, m_data, m_user, m_keep, m_last
  );

endinterface

// File: rtl/axis_dw_pack.sv
// Upsizing AXI-Stream converter: packs MEMBERS narrow members into one wide beat,
// flushing a partial beat on s_last. Fill register plus output register sustain one member per cycle.
module axis_dw_pack #(
  parameter int WORD_WIDTH   = axis_dw_pkg::DEF_WORD_WIDTH,
  parameter int UNITS        = axis_dw_pkg::DEF_UNITS,
  parameter int MEMBERS      = axis_dw_pkg::DEF_MEMBERS,
  parameter int TUSER_WIDTH  = axis_dw_pkg::DEF_TUSER_WIDTH,
  parameter int BITS_MEMBERS = $clog2(MEMBERS)
) (
  input  logic              aclk,
  input  logic              aresetn,
  axis_dw_pack_if.slave     bus
);

  typedef logic [UNITS-1:0][WORD_WIDTH-1:0] member_t;
  typedef logic [TUSER_WIDTH-1:0]           user_t;
  typedef member_t [MEMBERS-1:0]            beat_data_t;
  typedef user_t   [MEMBERS-1:0]            beat_user_t;

  localparam logic [BITS_MEMBERS-1:0] LAST_SLOT = BITS_MEMBERS'(MEMBERS - 1);

  beat_data_t              fill_data, next_data;
  beat_user_t              fill_user, next_user;
  logic [MEMBERS-1:0]      fill_keep, next_keep;
  logic [BITS_MEMBERS-1:0] cnt;
  logic                    pending;
  logic                    pending_last;

  logic accept, complete, out_free, handoff, handoff_last;

  // A completed fill waiting for the output register is the only source of backpressure.
  assign bus.s_ready   = !pending;
  assign accept        = bus.s_valid && !pending;
  assign complete      = accept && ((cnt == LAST_SLOT) || bus.s_last);
  assign out_free      = !bus.m_valid || bus.m_ready;
  assign handoff       = out_free && (complete || pending);
  assign handoff_last  = pending ? pending_last : bus.s_last;

  // Fill contents including the member accepted this cycle; this is what a handoff loads.
  always_comb begin
    // NOTE: every always_comb output gets a default before any conditional write, so no latch is inferred.
    next_data = fill_data;
    next_user = fill_user;
    next_keep = fill_keep;
    if (accept) begin
      next_data[cnt] = bus.s_data;
      next_user[cnt] = bus.s_user;
      next_keep[cnt] = 1'b1;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      // NOTE: the fill arrays are reset because unwritten slots of a partial beat must read as zero.
      fill_data    <= '0;
      fill_user    <= '0;
      fill_keep    <= '0;
      cnt          <= '0;
      pending      <= 1'b0;
      pending_last <= 1'b0;
    end else begin
      if (handoff) begin
        fill_data <= '0;
        fill_user <= '0;
        fill_keep <= '0;
      end else begin
        fill_data <= next_data;
        fill_user <= next_user;
        fill_keep <= next_keep;
      end

      if (complete)    cnt <= '0;
      else if (accept) cnt <= cnt + 1'b1;

      if (complete && !out_free) begin
        pending      <= 1'b1;
        pending_last <= bus.s_last;
      end else if (pending && out_free) begin
        pending      <= 1'b0;
      end
    end
  end

  // Output register changes only on handoff, so a stalled beat holds steady.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      bus.m_valid <= 1'b0;
      bus.m_data  <= '0;
      bus.m_user  <= '0;
      bus.m_keep  <= '0;
      bus.m_last  <= 1'b0;
    end else if (handoff) begin
      bus.m_valid <= 1'b1;
      bus.m_data  <= next_data;
      bus.m_user  <= next_user;
      bus.m_keep  <= next_keep;
      bus.m_last  <= handoff_last;
    end else if (bus.m_ready) begin
      bus.m_valid <= 1'b0;
    end
  end

endmodule

// File: doc/axis_dw_pack.md
# axis_dw_pack

Upsizing AXI-Stream width converter, the packing counterpart of `axis_dw_shift`. It accepts one member per beat (UNITS words plus its own tuser) and assembles MEMBERS consecutive members into one wide beat with a per-member keep. A partial wide beat is flushed on `s_last`. A fill register and an output register give full throughput of one member per cycle, with backpressure only when a completed beat cannot be handed off.

## Interface
- `WORD_WIDTH`, 8: bits per word.
- `UNITS`, 2: words per member.
- `MEMBERS`, 24: members per output beat; must be ≥ 2.
- `TUSER_WIDTH`, `` `TUSER_WIDTH_LRELU_IN ``: per-member user width.
- `BITS_MEMBERS`, `$clog2(MEMBERS)`: fill-counter width.

Ports:
- `aclk`  in  1  clock; all logic on rising edge.
- `aresetn`  in  1  reset; asynchronous, active-low.
- `s_valid`  in  1  input beat valid.
- `s_ready`  out  1  input beat accepted when high with `s_valid`.
- `s_data`  in  `[UNITS-1:0][WORD_WIDTH-1:0]`  one member.
- `s_user`  in  `[TUSER_WIDTH-1:0]`  that member's user.
- `s_last`  in  1  last member of packet; forces flush.
- `m_valid`  out  1  wide beat valid.
- `m_ready`  in  1  downstream accept.
- `m_data`  out  `[MEMBERS-1:0][UNITS-1:0][WORD_WIDTH-1:0]`  packed members.
- `m_user`  out  `[MEMBERS-1:0][TUSER_WIDTH-1:0]`  packed users.
- `m_keep`  out  `[MEMBERS-1:0]`  slot m holds a real member.
- `m_last`  out  1  beat ends a packet.

## Operation
- **Fill register.** Holds data/user/keep arrays plus counter `cnt` (0..MEMBERS-1). An accepted input (`s_valid && s_ready`) writes slot `cnt` and sets `keep[cnt]=1`.
- **Completion.** An accepted beat completes the fill when `cnt==MEMBERS-1` or `s_last==1`. The completed fill carries `last = s_last`.
- On completion, `cnt` wraps to 0 and the fill is handed to the output register if it is free, i.e. `!m_valid || m_ready` in that cycle. Otherwise `pending` is set.
- **Pending.** While `pending=1`, `s_ready=0`. The fill moves to the output on the first cycle where `!m_valid || m_ready`; `pending` then clears and `s_ready` returns high the next cycle.
- **Cleared slots.** After handoff, all fill data, user and keep are zero. Unwritten slots of a partial beat therefore output data=0, user=0, keep=0.
- **`s_last` on slot MEMBERS-1.** The beat is full with all keep set and `m_last=1`. No extra empty beat is emitted.
- **No `s_last` at slot boundary.** A full beat is emitted with `m_last=0`; packing continues at slot 0.
- **Output register.** Loaded only on handoff. Holds its value stably while `m_valid && !m_ready`, per AXIS. Clears `m_valid` on `m_ready` when no handoff occurs in the same cycle.
- **`s_ready`.** Equals `!pending`; it depends only on registered state.
- **Reset.** Asserting `aresetn` mid-packet discards the partial fill and any pending or held beat.

## Timing
- Reset values: `m_valid=0`, `m_last=0`, `m_keep=0`, `m_data=0`, `m_user=0`, `s_ready=1` (`pending=0`, `cnt=0`).
- Latency: the completing member is accepted at edge N, and `m_valid=1` with the packed beat is visible after edge N (first possible sampling at edge N+1).
- Throughput: with `m_ready` held high, one member is accepted every cycle indefinitely. A wide beat is emitted every MEMBERS cycles, or earlier on `s_last`.
- Simultaneous events:
  - Completion while the output is being consumed (`m_valid && m_ready`) hands off in the same edge, with no bubble.
  - `s_last` on two consecutive members produces two beats, each with 1 keep bit.
- Stall: a completion while `m_valid && !m_ready` gives `s_ready=0` from the next cycle until the output is accepted.

## Structure
- Shared package `axis_dw_pkg`:
  - typedefs `member_t` (`[UNITS-1:0][WORD_WIDTH-1:0]`) and `user_t`;
  - helper constant `BITS_MEMBERS`.
  - These are shared with `axis_dw_shift`.
- No sub-module. Fill and output registers are two `always_ff` blocks plus a small handoff/pending control.

## Test plan
All scenarios use MEMBERS=24, UNITS=2, WORD_WIDTH=8, `s_data[u] = m*10+u+1`, `s_user = m`.

1. **Full beat, continuous.** 24 members with `m_ready=1` and `s_last` on m=23 → one beat, all keep bits 1, `m_data[m][u] = m*10+u+1`, `m_user[m]=m`, `m_last=1`, `m_valid` one cycle after the 24th accept. `s_ready` never drops.
2. **Partial flush.** 5 members with `s_last` on the 5th → `m_keep = 24'h00001F`, slots 5..23 data/user zero, `m_last=1`. The next packet starts at slot 0.
3. **Multi-beat packet.** 50 members with `s_last` on the 50th → three beats with keep `FFFFFF`, `FFFFFF`, `000003`, and `m_last` = 0, 0, 1.
4. **Backpressure.** `m_ready=0` throughout 48 members → the first beat is held stable. The second completion sets `s_ready=0`. Raising `m_ready` for 3 cycles → both beats are delivered in order, then `s_ready=1`, with no data loss or duplication.
5. **Handoff on the consume edge.** 24+24 members continuous with `m_ready` toggled 1/0 → every completion coinciding with an `m_valid && m_ready` handshake produces no `s_ready` drop.
6. **Reset mid-fill.** Pulse `aresetn` low asynchronously after 10 members → all outputs 0 immediately, `s_ready=1`. A following 24-member packet is packed starting at slot 0.
